// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: opcode/word widths, memory-op opcodes,
// the MEM sequencer state encoding and opcode classification helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  localparam lc3b_opcode op_ldb = 4'b0010;
  localparam lc3b_opcode op_stb = 4'b0011;
  localparam lc3b_opcode op_ldr = 4'b0110;
  localparam lc3b_opcode op_str = 4'b0111;
  localparam lc3b_opcode op_ldi = 4'b1010;
  localparam lc3b_opcode op_sti = 4'b1011;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} mem_stage_state_t;

  function automatic logic is_load_op(lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
  endfunction

  function automatic logic is_store_op(lc3b_opcode op);
    return (op == op_str) || (op == op_stb) || (op == op_sti);
  endfunction

  function automatic logic is_mem_op(lc3b_opcode op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  function automatic logic is_byte_op(lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: store data replication and lane mask on the write side,
// selected-byte extraction with sign extension on the load side. Purely combinational.
module mem_byte_lane (
  input  logic [15:0] st_data,
  input  logic        st_lsb,
  input  logic        st_byte,
  output logic [15:0] st_wdata,
  output logic [1:0]  st_be,
  input  logic [15:0] ld_word,
  input  logic        ld_lsb,
  input  logic        ld_byte,
  output logic [15:0] ld_data
);

  logic [7:0] ld_sel;

  always_comb begin
    st_wdata = st_byte ? {st_data[7:0], st_data[7:0]} : st_data;
    st_be    = st_byte ? (st_lsb ? 2'b10 : 2'b01) : 2'b11;
    ld_sel   = ld_lsb ? ld_word[15:8] : ld_word[7:0];
    ld_data  = ld_byte ? {{8{ld_sel[7]}}, ld_sel} : ld_word;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage access sequencer: one cache access for LDR/LDB/STR/STB, two for LDI/STI
// when MEM_STAGE_INDIRECT_EN is defined (otherwise LDI/STI act as LDR/STR).
module mem_stage_ctrl
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  opcode,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] rdata,
  output logic        mem_stall,
  output logic        done
);

  mem_stage_state_t state_q, state_d;
  lc3b_opcode       op_q, op_d;
  logic             lsb_q, lsb_d;
  logic [15:0]      addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [1:0]       be_q, be_d;
  logic             start, ind_in, ind_q;
  logic [15:0]      st_wdata, ld_data;
  logic [1:0]       st_be;

`ifdef MEM_STAGE_INDIRECT_EN
  logic [14:0] ptr_q, ptr_d;
  logic [15:0] wdata_q, wdata_d;
  assign ind_in       = (opcode == op_ldi) || (opcode == op_sti);
  assign ind_q        = (op_q == op_ldi) || (op_q == op_sti);
  assign dmem_address = (state_q == SECOND) ? {ptr_q, 1'b0} : addr_q;
`else
  assign ind_in       = 1'b0;
  assign ind_q        = 1'b0;
  assign dmem_address = addr_q;
`endif

  mem_byte_lane u_lane (
    .st_data  (wdata),
    .st_lsb   (addr[0]),
    .st_byte  (opcode == op_stb),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_word  (dmem_rdata),
    .ld_lsb   (lsb_q),
    .ld_byte  (op_q == op_ldb),
    .ld_data  (ld_data)
  );

  assign start            = valid && is_mem_op(opcode);
  assign mem_stall        = ((state_q == IDLE) && start) || (state_q == FIRST) || (state_q == SECOND);
  assign done             = (state_q == DONE);
  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_wdata       = wd_q;
  assign dmem_byte_enable = be_q;
  assign rdata            = rdata_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lsb_d   = lsb_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
`ifdef MEM_STAGE_INDIRECT_EN
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST;
          op_d    = opcode;
          lsb_d   = addr[0];
          addr_d  = is_byte_op(opcode) ? addr : {addr[15:1], 1'b0};
          // Indirect stores fetch their pointer first, so only direct stores write here.
          wr_d    = is_store_op(opcode) && !ind_in;
          rd_d    = !wr_d;
          wd_d    = st_wdata;
          be_d    = wr_d ? st_be : 2'b11;
`ifdef MEM_STAGE_INDIRECT_EN
          wdata_d = wdata;
`endif
        end
      end
      FIRST: begin
        if (dmem_resp) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (ind_q) begin
            state_d = SECOND;
`ifdef MEM_STAGE_INDIRECT_EN
            ptr_d   = dmem_rdata[15:1];
            rd_d    = is_load_op(op_q);
            wr_d    = !is_load_op(op_q);
            wd_d    = wdata_q;
            be_d    = 2'b11;
`endif
          end else begin
            state_d = DONE;
            if (is_load_op(op_q)) rdata_d = ld_data;
          end
        end
      end
      SECOND: begin
        if (dmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (is_load_op(op_q)) rdata_d = dmem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      lsb_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
`ifdef MEM_STAGE_INDIRECT_EN
      ptr_q   <= '0;
      wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lsb_q   <= lsb_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
`ifdef MEM_STAGE_INDIRECT_EN
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then random instructions against a
// word-array memory and an access-list reference model.
module tb_mem_stage_ctrl;

`ifdef MEM_STAGE_INDIRECT_EN
  localparam bit INDIRECT = 1'b1;
`else
  localparam bit INDIRECT = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'b0001, OP_LDB = 4'b0010, OP_STB = 4'b0011,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_LDI = 4'b1010,
                         OP_STI = 4'b1011;

  logic        clk = 1'b0;
  logic        reset, valid, dmem_resp;
  logic [3:0]  opcode;
  logic [15:0] addr, wdata, dmem_rdata;
  logic        dmem_read, dmem_write, mem_stall, done;
  logic [15:0] dmem_address, dmem_wdata, rdata;
  logic [1:0]  dmem_byte_enable;

  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] exp_rdata = 16'h0000;
  logic [15:0] mem [0:32767];

  mem_stage_ctrl dut (
    .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .addr(addr),
    .wdata(wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .rdata(rdata),
    .mem_stall(mem_stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic is_mem(input logic [3:0] op);
    return op inside {OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI};
  endfunction

  // Issue one memory instruction and play the cache, responding after d0/d1 idle cycles.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] wd,
                        input int d0, input int d1);
    logic        ind, ld, st, bop;
    logic [15:0] acc_addr [2];
    logic        acc_wr   [2];
    logic [15:0] acc_wd   [2];
    logic [1:0]  acc_be   [2];
    logic [15:0] w;
    int          n, dl, stall_cnt, exp_stall;
    ld  = op inside {OP_LDR, OP_LDB, OP_LDI};
    st  = op inside {OP_STR, OP_STB, OP_STI};
    bop = (op == OP_LDB) || (op == OP_STB);
    ind = INDIRECT && (op == OP_LDI || op == OP_STI);
    acc_addr[0] = bop ? a : (a & 16'hFFFE);
    acc_wr[0]   = st && !ind;
    acc_wd[0]   = (op == OP_STB) ? {wd[7:0], wd[7:0]} : wd;
    acc_be[0]   = (acc_wr[0] && op == OP_STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    n = 1;
    if (ind) begin
      w           = mem[acc_addr[0][15:1]];
      acc_addr[1] = w & 16'hFFFE;
      acc_wr[1]   = (op == OP_STI);
      acc_wd[1]   = wd;
      acc_be[1]   = 2'b11;
      n = 2;
    end
    if (ld) begin
      w = mem[acc_addr[n-1][15:1]];
      if (op == OP_LDB) begin
        w = a[0] ? (w >> 8) : (w & 16'h00FF);
        exp_rdata = w[7] ? (w | 16'hFF00) : w;
      end else begin
        exp_rdata = w;
      end
    end
    exp_stall = 1 + (d0 + 1) + (ind ? d1 + 1 : 0);

    @(negedge clk);
    valid = 1'b1; opcode = op; addr = a; wdata = wd; dmem_resp = 1'b0;
    #1;
    check("issue_stall", mem_stall, 1'b1);
    check("issue_no_req", {dmem_read, dmem_write}, 2'b00);
    stall_cnt = int'(mem_stall);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      dl = (k == 0) ? d0 : d1;
      for (int c = 0; c <= dl; c++) begin
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check("req_read", dmem_read, !acc_wr[k]);
        check("req_write", dmem_write, acc_wr[k]);
        check("req_addr", dmem_address, acc_addr[k]);
        check("req_be", dmem_byte_enable, acc_be[k]);
        if (acc_wr[k]) check("req_wdata", dmem_wdata, acc_wd[k]);
        check("req_done_low", done, 1'b0);
        stall_cnt += int'(mem_stall);
        if (c == dl) begin
          dmem_resp = 1'b1;
          if (acc_wr[k]) begin
            if (acc_be[k][0]) mem[acc_addr[k][15:1]][7:0]  = acc_wd[k][7:0];
            if (acc_be[k][1]) mem[acc_addr[k][15:1]][15:8] = acc_wd[k][15:8];
            dmem_rdata = 16'($urandom);
          end else begin
            dmem_rdata = mem[acc_addr[k][15:1]];
          end
        end else begin
          dmem_rdata = 16'($urandom);
        end
        @(posedge clk);
      end
    end
    // Spurious response noise in DONE and IDLE must not disturb anything.
    @(negedge clk);
    valid = 1'b0; dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check("done_pulse", done, 1'b1);
    check("done_stall", mem_stall, 1'b0);
    check("done_no_req", {dmem_read, dmem_write}, 2'b00);
    check("done_rdata", rdata, exp_rdata);
    check("stall_cycles", 16'(stall_cnt), 16'(exp_stall));
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check("idle_done_low", done, 1'b0);
    check("idle_rdata_hold", rdata, exp_rdata);
    check("idle_no_req", {dmem_read, dmem_write}, 2'b00);
    dmem_resp = 1'b0;
  endtask

  task automatic run_nonmem(input logic v, input logic [3:0] op);
    @(negedge clk);
    valid = v; opcode = op; addr = 16'($urandom); wdata = 16'($urandom); dmem_resp = 1'b0;
    #1;
    check("nm_stall", mem_stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("nm_no_req", {dmem_read, dmem_write}, 2'b00);
    check("nm_done", done, 1'b0);
    check("nm_rdata", rdata, exp_rdata);
    valid = 1'b0;
  endtask

  initial begin
    logic [3:0] rop;
    logic       rv;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    reset = 1'b1; valid = 1'b0; opcode = 4'h0; addr = 16'h0; wdata = 16'h0;
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    #1;
    check("rst_read", dmem_read, 1'b0);
    check("rst_write", dmem_write, 1'b0);
    check("rst_addr", dmem_address, 16'h0000);
    check("rst_wdata", dmem_wdata, 16'h0000);
    check("rst_be", dmem_byte_enable, 2'b00);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    mem[16'h3004 >> 1] = 16'hBEEF;
    run_op(OP_LDR, 16'h3005, 16'h0000, 2, 0);
    check("ldr_beef", rdata, 16'hBEEF);
    mem[16'h3004 >> 1] = 16'h80FF;
    run_op(OP_LDB, 16'h3005, 16'h0000, 1, 0);
    check("ldb_hi_sext", rdata, 16'hFF80);
    mem[16'h3004 >> 1] = 16'h7F7F;
    run_op(OP_LDB, 16'h3004, 16'h0000, 0, 0);
    check("ldb_lo", rdata, 16'h007F);
    run_op(OP_STB, 16'h2001, 16'h00AB, 1, 0);
    check("stb_rdata_kept", rdata, 16'h007F);
    mem[16'h4000 >> 1] = 16'h5001;
    mem[16'h5000 >> 1] = 16'h1234;
    run_op(OP_LDI, 16'h4000, 16'h0000, 1, 2);
    check("ldi_result", rdata, INDIRECT ? 16'h1234 : 16'h5001);
    run_op(OP_STI, 16'h4000, 16'h0F0F, 0, 1);
    check("sti_target", INDIRECT ? mem[16'h5000 >> 1] : mem[16'h4000 >> 1], 16'h0F0F);

    for (int t = 0; t < 60; t++) begin
      rop = 4'($urandom);
      rv  = ($urandom_range(0, 3) != 0);
      if (rv && is_mem(rop))
        run_op(rop, 16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        run_nonmem(rv, rop);
    end

    // Abort an access mid-flight (SECOND when indirect is built, otherwise FIRST).
    @(negedge clk);
    valid = 1'b1; opcode = INDIRECT ? OP_LDI : OP_LDR; addr = 16'h4000; dmem_resp = 1'b0;
    @(posedge clk);
    if (INDIRECT) begin
      @(negedge clk);
      dmem_resp = 1'b1; dmem_rdata = 16'h5001;
      @(posedge clk);
    end
    @(negedge clk);
    dmem_resp = 1'b0; valid = 1'b0;
    #1;
    check("abort_pre_read", dmem_read, 1'b1);
    check("abort_pre_stall", mem_stall, 1'b1);
    reset = 1'b1;
    #1;
    exp_rdata = 16'h0000;
    check("abort_read", dmem_read, 1'b0);
    check("abort_write", dmem_write, 1'b0);
    check("abort_stall", mem_stall, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rdata", rdata, exp_rdata);
    @(negedge clk);
    reset = 1'b0;
    run_nonmem(1'b1, OP_ADD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
